// File: rtl/instr_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage_if
// Description : Fetch-stage bundle: control inputs, ROM bus, IF/ID outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_stage_if;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign_err;
    logic        oob_err;
    logic [31:0] fetch_count;

    // master: the fetch stage itself
    modport master (
        input  stall, flush, br_taken, br_target, imem_instr,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid,
               misalign_err, oob_err, fetch_count
    );

    // slave: surrounding pipeline, hazard unit and ROM
    modport slave (
        output stall, flush, br_taken, br_target, imem_instr,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
               misalign_err, oob_err, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage
// Description : PC, ROM address, IF/ID register, redirect/stall/flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_stage #(
    parameter int unsigned IMEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  wire logic clk,
    input  wire logic reset,
    instr_fetch_stage_if.master bus
);

    localparam logic [64:0] c_IMEM_LIMIT = 65'(IMEM_SIZE);

    logic [63:0] r_pc;
    logic [63:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_misalign_err;
    logic        r_oob_err;
    logic [31:0] r_fetch_count;

    logic [63:0] w_pc_seq;
    logic        w_in_range;

    assign w_pc_seq   = r_pc + 64'd4;
    // Extended by one bit so a PC near the top of the address space never wraps into range
    assign w_in_range = ({1'b0, r_pc} + 65'd3) < c_IMEM_LIMIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_if_id_pc     <= 64'd0;
            r_if_id_instr  <= NOP_INSTR;
            r_if_id_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_oob_err      <= 1'b0;
            r_fetch_count  <= 32'd0;
        end else if (bus.br_taken) begin
            r_pc          <= {bus.br_target[63:2], 2'b00};
            r_if_id_pc    <= 64'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            if (bus.br_target[1:0] != 2'b00) begin
                r_misalign_err <= 1'b1;
            end
        end else if (bus.flush) begin
            r_pc          <= w_pc_seq;
            r_if_id_pc    <= 64'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_pc       <= w_pc_seq;
            r_if_id_pc <= r_pc;
            if (w_in_range) begin
                r_if_id_instr <= bus.imem_instr;
                r_if_id_valid <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
                r_oob_err     <= 1'b1;
            end
        end
    end

    assign bus.imem_addr    = r_pc;
    assign bus.if_id_pc     = r_if_id_pc;
    assign bus.if_id_instr  = r_if_id_instr;
    assign bus.if_id_valid  = r_if_id_valid;
    assign bus.misalign_err = r_misalign_err;
    assign bus.oob_err      = r_oob_err;
    assign bus.fetch_count  = r_fetch_count;

endmodule
`default_nettype wire
